// File: rtl/gpu_bg_block_mem_ctrl.sv
// Background-block memory responder: saves/loads 256-bit BG blocks as BEAT_W beats.
// Optional macro GPU_BG_SKIP_EMPTY_BEAT_EN: SAVE skips beats whose byte enables are all zero.
module gpu_bg_block_mem_ctrl #(
  parameter int BEAT_W    = 32,
  parameter int MEM_ADR_W = 18
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_saveBGBlock,
  input  logic [14:0]            i_saveAdr,
  input  logic [14:0]            i_loadAdr,
  input  logic [255:0]           i_exportedBGBlock,
  input  logic [15:0]            i_exportedMSKBGBlock,
  output logic                   o_pausePipeline,
  output logic                   o_resetPixelMask,
  output logic                   o_resetPipelinePixelStateSpike,
  output logic                   o_importBGBlockSingleClock,
  output logic [255:0]           o_importedBGBlock,
  output logic                   o_memValid,
  input  logic                   i_memReady,
  output logic                   o_memWrite,
  output logic [MEM_ADR_W-1:0]   o_memAdr,
  output logic [BEAT_W-1:0]      o_memWData,
  output logic [BEAT_W/8-1:0]    o_memBE,
  input  logic                   i_memRValid,
  input  logic [BEAT_W-1:0]      i_memRData
);
  localparam int NB  = 256 / BEAT_W;
  localparam int BW  = $clog2(NB);
  localparam int BEB = BEAT_W / 8;
  localparam logic [BW:0] NBC  = (BW+1)'(NB);
  localparam logic [BW:0] LAST = (BW+1)'(NB - 1);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SAVE, S_LOAD, S_DONE, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [BW:0]    cnt_q, cnt_d;    // command beat counter
  logic [BW:0]    rcnt_q, rcnt_d;  // read response counter
  logic [1:0]     code_q;
  logic [14:0]    sadr_q, ladr_q;
  logic [255:0]   blk_q, imp_q;
  logic [15:0]    msk_q;
  logic [31:0]    be_all;
  logic [BEB-1:0] beat_be;
  logic [BEAT_W-1:0] beat_wd;
  logic           skip_beat, cmd_v, rsp_take;

  always_comb begin
    be_all = '0;
    for (int p = 0; p < 16; p++) be_all[2*p +: 2] = {2{msk_q[p]}};
  end

  assign beat_be = be_all[cnt_q[BW-1:0]*BEB +: BEB];
  assign beat_wd = blk_q[cnt_q[BW-1:0]*BEAT_W +: BEAT_W];

`ifdef GPU_BG_SKIP_EMPTY_BEAT_EN
  assign skip_beat = (beat_be == '0);
`else
  assign skip_beat = 1'b0;
`endif

  // Combinational so the backend freezes in the very cycle a code appears.
  assign o_pausePipeline   = (state_q != S_IDLE) | (i_saveBGBlock != 2'b00);
  assign o_importedBGBlock = imp_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    cmd_v    = 1'b0;
    rsp_take = 1'b0;
    o_resetPixelMask               = 1'b0;
    o_resetPipelinePixelStateSpike = 1'b0;
    o_importBGBlockSingleClock     = 1'b0;
    o_memValid = 1'b0;
    o_memWrite = 1'b0;
    o_memAdr   = '0;
    o_memWData = '0;
    o_memBE    = '0;
    case (state_q)
      S_IDLE: if (i_saveBGBlock != 2'b00) state_d = S_CAPTURE;
      S_CAPTURE: begin
        o_resetPixelMask = 1'b1;
        cnt_d  = '0;
        rcnt_d = '0;
        if (code_q[1] && msk_q != 16'h0) state_d = S_SAVE;
        else if (code_q == 2'b11)        state_d = S_DONE;
        else                             state_d = S_LOAD;
      end
      S_SAVE: begin
        o_memValid = ~skip_beat;
        o_memWrite = 1'b1;
        o_memAdr   = MEM_ADR_W'({sadr_q, cnt_q[BW-1:0]});
        o_memWData = beat_wd;
        o_memBE    = beat_be;
        if (skip_beat || i_memReady) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (code_q == 2'b10) ? S_LOAD : S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Commands and responses run on separate counters so they may overlap.
        cmd_v      = (cnt_q != NBC);
        o_memValid = cmd_v;
        o_memAdr   = MEM_ADR_W'({ladr_q, cnt_q[BW-1:0]});
        if (cmd_v && i_memReady) cnt_d = cnt_q + 1'b1;
        rsp_take = i_memRValid && (rcnt_q != NBC);
        if (rsp_take) rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == NBC) begin
          o_importBGBlockSingleClock = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_resetPipelinePixelStateSpike = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (i_saveBGBlock == 2'b00) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      code_q  <= '0;
      sadr_q  <= '0;
      ladr_q  <= '0;
      blk_q   <= '0;
      msk_q   <= '0;
      imp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      if (state_q == S_IDLE && i_saveBGBlock != 2'b00) begin
        code_q <= i_saveBGBlock;
        sadr_q <= i_saveAdr;
        ladr_q <= i_loadAdr;
        blk_q  <= i_exportedBGBlock;
        msk_q  <= i_exportedMSKBGBlock;
      end
      if (rsp_take) imp_q[rcnt_q[BW-1:0]*BEAT_W +: BEAT_W] <= i_memRData;
    end
  end
endmodule

// File: tb/tb_gpu_bg_block_mem_ctrl.sv
// Directed bench for gpu_bg_block_mem_ctrl: bench-side memory, per-cycle rule checks, per-transaction scoreboard.
module tb_gpu_bg_block_mem_ctrl;
  localparam int BEAT_W = 32, MEM_ADR_W = 18, NB = 8;
`ifdef GPU_BG_SKIP_EMPTY_BEAT_EN
  localparam int EXP_W2 = 1;
`else
  localparam int EXP_W2 = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst;
  logic [1:0] i_saveBGBlock;
  logic [14:0] i_saveAdr, i_loadAdr;
  logic [255:0] i_exportedBGBlock;
  logic [15:0] i_exportedMSKBGBlock;
  logic o_pausePipeline, o_resetPixelMask, o_resetPipelinePixelStateSpike, o_importBGBlockSingleClock;
  logic [255:0] o_importedBGBlock;
  logic o_memValid, i_memReady, o_memWrite, i_memRValid;
  logic [MEM_ADR_W-1:0] o_memAdr;
  logic [BEAT_W-1:0] o_memWData, i_memRData;
  logic [BEAT_W/8-1:0] o_memBE;

  gpu_bg_block_mem_ctrl #(.BEAT_W(BEAT_W), .MEM_ADR_W(MEM_ADR_W)) dut (
    .clk(clk), .i_rst(i_rst), .i_saveBGBlock(i_saveBGBlock), .i_saveAdr(i_saveAdr), .i_loadAdr(i_loadAdr),
    .i_exportedBGBlock(i_exportedBGBlock), .i_exportedMSKBGBlock(i_exportedMSKBGBlock),
    .o_pausePipeline(o_pausePipeline), .o_resetPixelMask(o_resetPixelMask),
    .o_resetPipelinePixelStateSpike(o_resetPipelinePixelStateSpike),
    .o_importBGBlockSingleClock(o_importBGBlockSingleClock), .o_importedBGBlock(o_importedBGBlock),
    .o_memValid(o_memValid), .i_memReady(i_memReady), .o_memWrite(o_memWrite), .o_memAdr(o_memAdr),
    .o_memWData(o_memWData), .o_memBE(o_memBE), .i_memRValid(i_memRValid), .i_memRData(i_memRData));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Memory content: beat j of block b reads back as {b, 16'hA000 + j}.
  function automatic logic [31:0] mdata(input logic [17:0] a);
    return {1'b0, a[17:3], 16'h0} + 32'h0000A000 + {29'd0, a[2:0]};
  endfunction

  // ---------------- bench memory ----------------
  logic [31:0] rq_dat[$];
  int rq_due[$];
  int rsp_sent = 0, stall_left = 0;

  initial begin
    i_memReady = 1'b1; i_memRValid = 1'b0; i_memRData = '0;
    forever begin
      @(posedge clk); #1;
      i_memReady = 1'b1;
      if (stall_left > 0 && o_memValid && o_memWrite && o_memAdr[2:0] == 3'd3) begin
        i_memReady = 1'b0;
        stall_left--;
      end
      i_memRValid = 1'b0; i_memRData = '0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        i_memRValid = 1'b1;
        i_memRData  = rq_dat.pop_front();
        void'(rq_due.pop_front());
        rsp_sent++;
      end
      #2;
      if (o_memValid && i_memReady && !o_memWrite && !i_rst) begin
        rq_dat.push_back(mdata(o_memAdr));
        rq_due.push_back(cyc + 2);
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  logic [17:0] wadr[$], radr[$];
  logic [31:0] wdat[$];
  logic [3:0]  wbe[$];
  int mask_n, imp_n, spike_n, mask_c, imp_c, spike_c;
  logic [255:0] imp_d;
  bit busy_m = 0, spike_seen = 0, prev_stall = 0;
  logic [55:0] prev_cmd;

  always @(posedge clk) begin
    int s;
    #3;
    chk("pause", o_pausePipeline, busy_m || (i_saveBGBlock != 2'b00));
    if (!busy_m) chk("idle_no_traffic", o_memValid, 1'b0);
    s = int'(o_resetPixelMask) + int'(o_importBGBlockSingleClock) + int'(o_resetPipelinePixelStateSpike);
    chk("pulse_exclusive", s <= 1, 1'b1);
    if (prev_stall && !i_rst)
      chk("stall_hold", {o_memValid, o_memWrite, o_memAdr, o_memWData, o_memBE}, prev_cmd);
    if (!i_rst) begin
      if (o_memValid && i_memReady) begin
        if (o_memWrite) begin wadr.push_back(o_memAdr); wdat.push_back(o_memWData); wbe.push_back(o_memBE); end
        else radr.push_back(o_memAdr);
      end
      if (o_resetPixelMask) begin mask_n++; mask_c = cyc; end
      if (o_importBGBlockSingleClock) begin imp_n++; imp_c = cyc; imp_d = o_importedBGBlock; end
      if (o_resetPipelinePixelStateSpike) begin spike_n++; spike_c = cyc; end
    end
    prev_stall = o_memValid && !i_memReady && !i_rst;
    prev_cmd   = {o_memValid, o_memWrite, o_memAdr, o_memWData, o_memBE};
    // A transaction lasts until the code is seen at 00 in some cycle after its spike.
    if (i_rst) begin busy_m = 0; spike_seen = 0; end
    else if (!busy_m && i_saveBGBlock != 2'b00) begin busy_m = 1; spike_seen = 0; end
    else if (busy_m && spike_seen && i_saveBGBlock == 2'b00) busy_m = 0;
    if (o_resetPipelinePixelStateSpike && !i_rst) spike_seen = 1;
  end

  // ---------------- scoreboard ----------------
  task automatic clear_logs();
    wadr.delete(); wdat.delete(); wbe.delete(); radr.delete();
    mask_n = 0; imp_n = 0; spike_n = 0; mask_c = 0; imp_c = 0; spike_c = 0;
  endtask

  task automatic check_txn(input logic [1:0] code, input logic [14:0] sa, input logic [14:0] la,
                           input logic [255:0] blk, input logic [15:0] m);
    bit do_save, do_load;
    logic [17:0] ea[$];
    logic [31:0] ed[$];
    logic [3:0]  eb[$];
    logic [255:0] eblk;
    do_save = code[1] && (m != 16'h0);
    do_load = (code == 2'b01) || (code == 2'b10);
    for (int k = 0; k < NB; k++) begin
      logic [3:0] be;
      be = {m[2*k+1], m[2*k+1], m[2*k], m[2*k]};
      if (do_save) begin
`ifdef GPU_BG_SKIP_EMPTY_BEAT_EN
        if (be != 4'h0) begin ea.push_back({sa, 3'(k)}); ed.push_back(blk[32*k +: 32]); eb.push_back(be); end
`else
        ea.push_back({sa, 3'(k)}); ed.push_back(blk[32*k +: 32]); eb.push_back(be);
`endif
      end
      eblk[32*k +: 32] = mdata({la, 3'(k)});
    end
    chk("wr_count", wadr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wadr.size(); i++) begin
      chk("wr_adr", wadr[i], ea[i]);
      chk("wr_data", wdat[i], ed[i]);
      chk("wr_be", wbe[i], eb[i]);
    end
    chk("rd_count", radr.size(), do_load ? NB : 0);
    for (int i = 0; i < NB && i < radr.size(); i++) chk("rd_adr", radr[i], {la, 3'(i)});
    chk("mask_pulses", mask_n, 1);
    chk("spike_pulses", spike_n, 1);
    chk("import_pulses", imp_n, do_load ? 1 : 0);
    chk("order_mask_spike", mask_c < spike_c, 1'b1);
    if (do_load) begin
      chk("order_import", (mask_c < imp_c) && (imp_c < spike_c), 1'b1);
      chk("import_data", imp_d, eblk);
    end
  endtask

  task automatic run_txn(input logic [1:0] code, input logic [14:0] sa, input logic [14:0] la,
                         input logic [255:0] blk, input logic [15:0] m, input int stall, input int hold);
    int n;
    clear_logs();
    stall_left = stall;
    @(posedge clk); #1;
    i_saveAdr = sa; i_loadAdr = la; i_exportedBGBlock = blk; i_exportedMSKBGBlock = m; i_saveBGBlock = code;
    n = 0;
    while (spike_n == 0 && n < 400) begin @(posedge clk); #4; n++; end
    chk("txn_timeout", spike_n != 0, 1'b1);
    repeat (hold) @(posedge clk);
    #1 i_saveBGBlock = 2'b00;
    repeat (3) @(posedge clk);
    #4 check_txn(code, sa, la, blk, m);
  endtask

  logic [255:0] blk2, blk3;

  initial begin
    int n, base;
    i_rst = 1'b1; i_saveBGBlock = 2'b00; i_saveAdr = '0; i_loadAdr = '0;
    i_exportedBGBlock = '0; i_exportedMSKBGBlock = '0;
    for (int p = 0; p < 16; p++) begin
      blk2[16*p +: 16] = 16'hB000 + 16'(p);
      blk3[16*p +: 16] = 16'h5A00 ^ 16'(p * 37);
    end
    repeat (3) @(posedge clk);
    #4;
    chk("rst_pause", o_pausePipeline, 1'b0);
    chk("rst_valid", o_memValid, 1'b0);
    chk("rst_mask", o_resetPixelMask, 1'b0);
    chk("rst_spike", o_resetPipelinePixelStateSpike, 1'b0);
    chk("rst_import", o_importBGBlockSingleClock, 1'b0);
    chk("rst_block", o_importedBGBlock, 256'h0);
    @(posedge clk); #1 i_rst = 1'b0;

    // Load-only.
    run_txn(2'b01, 15'h0000, 15'h0123, 256'h0, 16'h0000, 0, 2);
    chk("pin_rd0_adr", radr[0], 18'h00918);
    chk("pin_imp_lo", imp_d[31:0], 32'h0123A000);
    chk("pin_imp_hi", imp_d[255:224], 32'h0123A007);

    // Save + load, only pixels 0 and 1 written.
    run_txn(2'b10, 15'h0010, 15'h0011, blk2, 16'h0003, 0, 2);
    chk("pin_wr_n", wadr.size(), EXP_W2);
    chk("pin_wr0_adr", wadr[0], 18'h00080);
    chk("pin_wr0_be", wbe[0], 4'hF);
    chk("pin_wr0_data", wdat[0], 32'hB001B000);
    chk("pin_rd0_adr2", radr[0], 18'h00088);

    // Flush with empty mask, code held long: no traffic, no retrigger.
    run_txn(2'b11, 15'h0020, 15'h0000, blk2, 16'h0000, 0, 20);
    chk("pin_flush_nowr", wadr.size(), 0);

    // Flush with full mask and back-pressure on beat 3.
    run_txn(2'b11, 15'h0040, 15'h0000, blk3, 16'hFFFF, 5, 2);
    chk("pin_stall_used", stall_left, 0);
    chk("pin_stall_wr_n", wadr.size(), 8);
    chk("pin_stall_wr3", wadr[3], 18'h00203);

    // Reset in the middle of a load, then a fresh load.
    clear_logs();
    base = rsp_sent;
    @(posedge clk); #1;
    i_loadAdr = 15'h0155; i_saveBGBlock = 2'b01;
    n = 0;
    while ((rsp_sent - base) < 4 && n < 200) begin @(posedge clk); #2; n++; end
    chk("rst_wait_timeout", (rsp_sent - base) >= 4, 1'b1);
    @(posedge clk); #1;
    i_rst = 1'b1; i_saveBGBlock = 2'b00;
    @(posedge clk); #1 i_rst = 1'b0;
    #2;
    chk("abort_pause", o_pausePipeline, 1'b0);
    chk("abort_valid", o_memValid, 1'b0);
    chk("abort_write", o_memWrite, 1'b0);
    chk("abort_adr", o_memAdr, 18'h0);
    chk("abort_pulses", {o_resetPixelMask, o_importBGBlockSingleClock, o_resetPipelinePixelStateSpike}, 3'b000);
    chk("abort_block", o_importedBGBlock, 256'h0);
    repeat (5) @(posedge clk);
    run_txn(2'b01, 15'h0000, 15'h0200, 256'h0, 16'h0000, 0, 2);
    chk("pin_fresh_imp3", imp_d[127:96], 32'h0200A003);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_bg_block_mem_ctrl.md
Name: gpu_bg_block_mem_ctrl

Overview:
Memory-side responder for the GPU backend's background-block (BG) cache port: it consumes the save/load requests the backend raises on its new-block signals. Save requests write the 16-pixel (256-bit) block back to VRAM/DDR with per-pixel byte enables; load requests fetch the next block and return it through the single-cycle import strobe. While a transaction is active it holds the backend pipeline paused, then issues the mask-clear and state-spike-clear pulses the backend expects.

Parameters:
BEAT_W, 32, memory data beat width in bits; legal values 32, 64, 128; NUM_BEATS = 256/BEAT_W.
MEM_ADR_W, 18, beat address width; must be at least 15 + log2(NUM_BEATS).

Ports:
clk  in  1  clock
i_rst  in  1  synchronous reset, active high
i_saveBGBlock  in  2  backend pair code: 00 none, 01 first (load only), 10 next (save+load), 11 flush (save only)
i_saveAdr  in  15  block address to save
i_loadAdr  in  15  block address to load
i_exportedBGBlock  in  256  block data, pixel p at bits [16p+15:16p]
i_exportedMSKBGBlock  in  16  per-pixel written mask
o_pausePipeline  out  1  freeze request to backend
o_resetPixelMask  out  1  1-cycle pulse: backend clears mask
o_resetPipelinePixelStateSpike  out  1  1-cycle pulse: backend clears new-block flag
o_importBGBlockSingleClock  out  1  1-cycle strobe: o_importedBGBlock valid
o_importedBGBlock  out  256  loaded block
o_memValid  out  1  command valid
i_memReady  in  1  command accepted when valid&ready
o_memWrite  out  1  1 write, 0 read
o_memAdr  out  MEM_ADR_W  {blockAdr, beatIdx}
o_memWData  out  BEAT_W  write data
o_memBE  out  BEAT_W/8  byte enables
i_memRValid  in  1  read response beat, in order
i_memRData  in  BEAT_W  read data

Behaviour:
- Reset: state IDLE; all outputs 0; counters cleared; outstanding responses dropped; i_memRValid ignored until the next LOAD. Reset mid-transaction aborts with no pulses.
- o_pausePipeline = (state != IDLE) | (i_saveBGBlock != 00), combinational, so the backend freezes in the same cycle the code appears.
- IDLE: if i_saveBGBlock != 00, snapshot code, addresses, block and mask into registers -> CAPTURE.
- CAPTURE (1 cycle): pulse o_resetPixelMask. Next state: SAVE if code[1] and snapshot mask != 0; LOAD if code == 01 or (code == 10 and mask == 0); DONE if code == 11 and mask == 0.
- SAVE: beats k = 0..NUM_BEATS-1 in order. o_memWrite = 1, o_memAdr = {saveAdr, k}, o_memWData = block slice k. o_memBE byte pair for pixel p = mask[p] replicated. Beat counter advances only on valid&ready; command fields stay stable while ready is low. After the last accepted beat: LOAD if code == 10, else DONE.
- LOAD: issue NUM_BEATS read commands {loadAdr, k}. Independently count responses; response j fills slice j of the import register. Commands may overlap responses. When response NUM_BEATS-1 arrives, o_importBGBlockSingleClock pulses the next cycle with the full block -> DONE.
- DONE (1 cycle): pulse o_resetPipelinePixelStateSpike -> WAIT_REL.
- WAIT_REL: stay until i_saveBGBlock == 00, then IDLE. A held flush code (11) must not retrigger.
- A response received outside LOAD, or beyond NUM_BEATS, is ignored.
- Pulse order per transaction: resetPixelMask, then (loads) import, then resetPipelinePixelStateSpike; never the same cycle.

Optional Feature:
GPU_BG_SKIP_EMPTY_BEAT_EN: when defined, SAVE skips any beat whose byte enables are all zero (counter advances without asserting o_memValid, 1 cycle per skipped beat). When undefined, every beat is issued, including zero-BE beats.

Test Plan:
- Code 01, loadAdr=0x0123, memory returns pattern beat j = 0xA000+j -> 8 reads to adr {0x0123,0..7}; import strobe exactly once with matching 256-bit block; resetPixelMask then resetSpike pulses; no write.
- Code 10, mask=0x0003, saveAdr=0x0010, loadAdr=0x0011 -> beat0 BE=0xF, beats1-7 BE=0 (8 writes; only beat0 with macro), then 8 reads at 0x0011.
- Code 11, mask=0x0000 -> no memory traffic; resetPixelMask, resetSpike pulses; code held at 11 for 20 cycles -> no second transaction.
- i_memReady low 5 cycles during SAVE beat 3 -> adr/data/BE stable, no beat lost, total 8 writes.
- i_rst asserted during LOAD after 4 responses -> all outputs 0 next cycle; later code 01 completes a correct fresh load.
- o_pausePipeline high in the same cycle i_saveBGBlock goes nonzero, low only after WAIT_REL sees 00.
